// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT input path (FIFO and block unpacker).
package fft_pkg;

  localparam int unsigned FFT_BLOCK_BITS        = 512;
  localparam int unsigned FFT_SAMPLES_PER_BLOCK = 8;

  // One FIFO word: a block of packed complex samples, lane 0 in the LSBs.
  typedef logic [FFT_BLOCK_BITS-1:0] t_block;

  // One complex sample: re in the low half, im in the high half.
  typedef struct packed {
    logic [31:0] im;
    logic [31:0] re;
  } t_sample;

  // Unpacker control state: no block held / block held and being emitted.
  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } t_state;

endpackage

// File: rtl/fft_block_unpacker_if.sv
// FIFO read port, sample stream and status of the FFT block unpacker.
interface fft_block_unpacker_if #(
  parameter int unsigned SAMPLE_WIDTH = 64,
  parameter int unsigned FFT_POINTS   = 1024
);
  import fft_pkg::*;

  localparam int unsigned IDX_W = $clog2(FFT_POINTS);

  logic                    clear;
  t_block                  fifo_deq_data;
  logic                    fifo_not_empty;
  logic                    fifo_deq_en;
  logic [SAMPLE_WIDTH-1:0] sample_data;
  logic                    sample_valid;
  logic                    sample_ready;
  logic                    sample_first;
  logic                    sample_last;
  logic [IDX_W-1:0]        sample_index;
  logic [31:0]             frames_done;

  // Unpacker side.
  modport master (
    input  clear, fifo_deq_data, fifo_not_empty, sample_ready,
    output fifo_deq_en, sample_data, sample_valid, sample_first,
           sample_last, sample_index, frames_done
  );

  // FIFO / FFT-core / control side.
  modport slave (
    output clear, fifo_deq_data, fifo_not_empty, sample_ready,
    input  fifo_deq_en, sample_data, sample_valid, sample_first,
           sample_last, sample_index, frames_done
  );

endinterface

// File: rtl/fft_block_unpacker.sv
// Pops 512-bit blocks from a FWFT FIFO and serialises them into a
// frame-tagged complex-sample stream, one sample per cycle when fed.
module fft_block_unpacker
  import fft_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH      = 64,
  parameter int unsigned SAMPLES_PER_BLOCK = FFT_SAMPLES_PER_BLOCK,
  parameter int unsigned FFT_POINTS        = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  fft_block_unpacker_if.master  bus
);

  localparam int unsigned LANE_W = $clog2(SAMPLES_PER_BLOCK);
  localparam int unsigned IDX_W  = $clog2(FFT_POINTS);

  t_state              state_q, state_d;
  t_block              block_q, block_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic [IDX_W-1:0]    index_q, index_d;
  logic [31:0]         frames_q, frames_d;

  logic                valid_c;
  logic                xfer_c;
  logic                last_lane_c;
  logic                first_c;
  logic                last_c;
  logic                deq_c;
  logic [SAMPLE_WIDTH-1:0] lanes [SAMPLES_PER_BLOCK];

  // Slice the held block into its sample lanes.
  for (genvar g = 0; g < SAMPLES_PER_BLOCK; g++) begin : g_lane
    assign lanes[g] = block_q[g*SAMPLE_WIDTH +: SAMPLE_WIDTH];
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state; clear always lands in S_IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (deq_c) state_d = S_EMIT;
      S_EMIT: if (xfer_c && last_lane_c && !bus.fifo_not_empty) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (bus.clear) state_d = S_IDLE;
  end

  // FSM outputs: stream valid, transfer and pop strobe (held off in reset and clear).
  always_comb begin
    valid_c     = (state_q == S_EMIT);
    last_lane_c = (lane_q == LANE_W'(SAMPLES_PER_BLOCK - 1));
    xfer_c      = valid_c && bus.sample_ready && !bus.clear;
    first_c     = valid_c && (index_q == '0);
    last_c      = valid_c && (index_q == IDX_W'(FFT_POINTS - 1));
    deq_c       = 1'b0;
    case (state_q)
      S_IDLE: deq_c = bus.fifo_not_empty && !bus.clear;
      S_EMIT: deq_c = xfer_c && last_lane_c && bus.fifo_not_empty;
      default: deq_c = 1'b0;
    endcase
    if (reset) deq_c = 1'b0;
  end

  // Datapath next state: block load, lane advance, frame index and frame count.
  always_comb begin
    block_d  = block_q;
    lane_d   = lane_q;
    index_d  = index_q;
    frames_d = frames_q;
    if (bus.clear) begin
      block_d  = '0;
      lane_d   = '0;
      index_d  = '0;
      frames_d = '0;
    end else begin
      if (deq_c) begin
        block_d = bus.fifo_deq_data;
        lane_d  = '0;
      end else if (xfer_c) begin
        lane_d = lane_q + LANE_W'(1);
      end
      if (xfer_c) begin
        index_d = index_q + IDX_W'(1);
        if (last_c) frames_d = frames_q + 32'd1;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      block_q  <= '0;
      lane_q   <= '0;
      index_q  <= '0;
      frames_q <= '0;
    end else begin
      block_q  <= block_d;
      lane_q   <= lane_d;
      index_q  <= index_d;
      frames_q <= frames_d;
    end
  end

  assign bus.fifo_deq_en  = deq_c;
  assign bus.sample_valid = valid_c;
  assign bus.sample_data  = lanes[lane_q];
  assign bus.sample_first = first_c;
  assign bus.sample_last  = last_c;
  assign bus.sample_index = index_q;
  assign bus.frames_done  = frames_q;

endmodule

// File: doc/fft_block_unpacker.md
Name: fft_block_unpacker

Overview:
Downstream consumer of the FFT input FIFO. It pops 512-bit blocks from the FIFO's first-word-fall-through read port and serialises each block into SAMPLES_PER_BLOCK complex samples on a valid/ready stream feeding the FFT butterfly core. It tags frame boundaries (first/last), tracks each sample's index within the FFT frame, and counts completed frames. With a non-empty FIFO it sustains one sample per cycle, including across block boundaries.

Parameters:
SAMPLE_WIDTH, 64, bits per complex sample; re = [31:0], im = [63:32].
SAMPLES_PER_BLOCK, 8, samples per 512-bit block; must equal 512/SAMPLE_WIDTH.
FFT_POINTS, 1024, samples per frame; power of 2 and a multiple of SAMPLES_PER_BLOCK.

Ports:
clk  in  1  single clock; all state on posedge.
reset  in  1  asynchronous, active-high reset.
clear  in  1  synchronous soft clear; drops the held block and zeroes counters.
fifo_deq_data  in  512  head-of-FIFO block; valid whenever fifo_not_empty=1.
fifo_not_empty  in  1  FIFO holds at least one block.
fifo_deq_en  out  1  pop strobe; combinational; never high unless fifo_not_empty=1.
sample_data  out  SAMPLE_WIDTH  current sample.
sample_valid  out  1  sample_data is valid.
sample_ready  in  1  FFT core accepts the sample.
sample_first  out  1  current sample is index 0 of a frame.
sample_last  out  1  current sample is index FFT_POINTS-1.
sample_index  out  $clog2(FFT_POINTS)  index of the current sample within its frame.
frames_done  out  32  count of frames fully accepted (wraps at 2^32).

Behaviour:
- Reset values: state=S_IDLE, block_q=0, lane=0, sample_index=0, frames_done=0. During reset, sample_valid, sample_first, sample_last and fifo_deq_en are all 0.
- Handshake: a sample transfers when sample_valid & sample_ready. Once sample_valid is asserted, sample_data, sample_first, sample_last and sample_index hold stable until the transfer.
- FSM S_IDLE (no block held):
  - fifo_deq_en = fifo_not_empty & !clear.
  - On pop: block_q <= fifo_deq_data, lane <= 0, next state S_EMIT.
- FSM S_EMIT (block held):
  - sample_valid = 1; sample_data = block_q[lane*SAMPLE_WIDTH +: SAMPLE_WIDTH].
  - Transfer with lane < SAMPLES_PER_BLOCK-1: lane <= lane+1.
  - Transfer with lane = SAMPLES_PER_BLOCK-1 and fifo_not_empty: fifo_deq_en=1, reload block_q, lane <= 0, stay in S_EMIT. This avoids a bubble at the block boundary.
  - Transfer with lane = SAMPLES_PER_BLOCK-1 and FIFO empty: go to S_IDLE; fifo_deq_en=0.
  - No transfer: all state holds; fifo_deq_en=0.
- Latency: a pop in cycle N produces sample_valid=1 with lane 0 in cycle N+1.
- Frame tracking:
  - sample_first = (sample_index==0); sample_last = (sample_index==FFT_POINTS-1).
  - sample_index increments on every transfer and wraps from FFT_POINTS-1 to 0.
  - frames_done increments on the transfer of the sample_last sample.
  - Frames may span any number of blocks. The block boundary and the frame boundary coincide at every FFT_POINTS/SAMPLES_PER_BLOCK blocks.
- Backpressure: with sample_ready=0 no pop occurs, even if the FIFO fills.
- clear (synchronous, overrides every other update that cycle):
  - next state S_IDLE; lane, sample_index and frames_done <= 0.
  - The held block is discarded; fifo_deq_en is forced to 0.
  - No sample transfers in the clear cycle.
- Asynchronous reset mid-frame: immediate return to reset values; the partial block is lost. Realigning the FIFO is upstream's responsibility.
- Width rules: lane is $clog2(SAMPLES_PER_BLOCK) bits; sample_index is $clog2(FFT_POINTS) bits. Both wrap naturally because their ranges are powers of 2.

Decomposition:
- fft_pkg holds:
  - t_block (512-bit block type, shared with the FIFO);
  - t_sample, a packed struct {logic [31:0] im; logic [31:0] re;};
  - constants FFT_BLOCK_BITS=512 and FFT_SAMPLES_PER_BLOCK=8.
- Sub-module: none. The FSM, lane counter and frame counters fit in one module; a separate frame counter adds no reuse.

Test Plan:
- Single block, sample_ready=1: FIFO holds block whose 64-bit lanes are 0x0..0x7 -> fifo_deq_en pulses one cycle; samples 0..7 on 8 consecutive cycles; sample_first on the first; sample_valid=0 on cycle 9.
- Back-to-back blocks, sample_ready=1: FIFO holds 3 blocks -> 24 consecutive valid cycles with no bubble; fifo_deq_en high in cycles 0, 8 and 16 only.
- Backpressure: sample_ready toggles 1,0,0,1,... -> no sample dropped or duplicated; data stable while stalled; no pop while lane<7 or while the lane-7 sample is stalled.
- Frame wrap with FFT_POINTS=16: feed 4 blocks -> sample_last on samples 15 and 31; frames_done steps 0->1->2; sample_index wraps to 0.
- clear at lane 3 of a block -> sample_valid drops next cycle; frames_done=0; the next pop starts at lane 0 with sample_index 0.
- Async reset asserted mid-block with FIFO non-empty -> all outputs at reset values in the same cycle; fifo_deq_en=0 throughout reset.
